riscv_hazard_fwd_unit: RTL and testbench

Parametrised forwarding and hazard-control unit for the pipelined RISC-V core, serving the EX stage. It generalises operand forwarding to N write-back-carrying pipeline stages with nearest-stage priority. It adds a separate store-data forward path and a sequential load-use stall controller for multi-cycle data memory. A pipeline-wide freeze on data-memory busy is also included.

---
 rtl/riscv_hazard_pkg.sv | 13 +
 rtl/riscv_hazard_fwd_unit_match.sv | 30 +++
 rtl/riscv_hazard_fwd_unit.sv | 117 +++++++++++
 tb/tb_riscv_hazard_fwd_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hazard_pkg.sv
// riscv_hazard_pkg: shared types and helpers for the EX-stage hazard/forwarding unit.
package riscv_hazard_pkg;

    typedef enum logic [1:0] {ST_RUN, ST_LU_STALL, ST_MEM_WAIT} hz_state_t;

    localparam int FWD_RF     = 0;
    localparam int MAX_STAGES = 4;

    function automatic logic [4:0] stg_field(input logic [5*MAX_STAGES-1:0] v, input int k);
        return v[5*k-5 +: 5];
    endfunction

endpackage

// File: rtl/riscv_hazard_fwd_unit_match.sv
// hazard_fwd_match: nearest-stage priority matcher producing one forward select.
module hazard_fwd_match
    import riscv_hazard_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LATENCY   = 1,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES+1)
) (
    input  logic [4:0]                  i_reg,
    input  logic                        i_en,
    input  logic [5*NUM_FWD_STAGES-1:0] i_stg_wreg,
    input  logic [NUM_FWD_STAGES-1:0]   i_stg_regwrite,
    input  logic [NUM_FWD_STAGES-1:0]   i_stg_memtoreg,
    output logic [SEL_W-1:0]            o_sel
);

    logic [5*MAX_STAGES-1:0] w_wreg;

    assign w_wreg = (5*MAX_STAGES)'(i_stg_wreg);

    // Scan far to near so the nearest forwardable stage overwrites the others.
    always_comb begin
        o_sel = SEL_W'(FWD_RF);
        for (int k = NUM_FWD_STAGES; k >= 1; k--)
            if (i_en && i_stg_regwrite[k-1] && stg_field(w_wreg, k) != 5'd0 &&
                stg_field(w_wreg, k) == i_reg && !(i_stg_memtoreg[k-1] && k <= LOAD_LATENCY))
                o_sel = SEL_W'(k);
    end

endmodule

// File: rtl/riscv_hazard_fwd_unit.sv
// riscv_hazard_fwd_unit: EX-stage operand/store-data forwarding plus load-use stall and dmem freeze control.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module riscv_hazard_fwd_unit
    import riscv_hazard_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LATENCY   = 1,
    parameter int SEL_W          = $clog2(NUM_FWD_STAGES+1)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [4:0]                  i_id_rs1,
    input  logic [4:0]                  i_id_rs2,
    input  logic                        i_id_use_rs1,
    input  logic                        i_id_use_rs2,
    input  logic [4:0]                  i_ex_rs1,
    input  logic [4:0]                  i_ex_rs2,
    input  logic                        i_ex_b_is_imm,
    input  logic                        i_ex_mem_write,
    input  logic [4:0]                  i_id_ex_wreg,
    input  logic                        i_id_ex_memtoreg,
    input  logic [5*NUM_FWD_STAGES-1:0] i_stg_wreg,
    input  logic [NUM_FWD_STAGES-1:0]   i_stg_regwrite,
    input  logic [NUM_FWD_STAGES-1:0]   i_stg_memtoreg,
    input  logic                        i_flush,
    input  logic                        i_dmem_busy,
    output logic [SEL_W-1:0]            o_fw_a,
    output logic [SEL_W-1:0]            o_fw_b,
    output logic [SEL_W-1:0]            o_fw_sd,
    output logic                        o_pc_hold,
    output logic                        o_ifid_hold,
    output logic                        o_idex_bubble,
    output logic                        o_freeze,
    output logic [31:0]                 o_stall_cycles,
    output logic [31:0]                 o_fwd_events
);

    localparam int CW = $clog2(LOAD_LATENCY+1);

    hz_state_t     r_state, r_ret, w_eff;
    logic [CW-1:0] r_cnt;
    logic          w_hazard, w_stall;

    hazard_fwd_match #(.NUM_FWD_STAGES(NUM_FWD_STAGES), .LOAD_LATENCY(LOAD_LATENCY), .SEL_W(SEL_W)) u_match_a (
        .i_reg(i_ex_rs1), .i_en(1'b1), .i_stg_wreg(i_stg_wreg),
        .i_stg_regwrite(i_stg_regwrite), .i_stg_memtoreg(i_stg_memtoreg), .o_sel(o_fw_a));

    hazard_fwd_match #(.NUM_FWD_STAGES(NUM_FWD_STAGES), .LOAD_LATENCY(LOAD_LATENCY), .SEL_W(SEL_W)) u_match_b (
        .i_reg(i_ex_rs2), .i_en(!i_ex_b_is_imm), .i_stg_wreg(i_stg_wreg),
        .i_stg_regwrite(i_stg_regwrite), .i_stg_memtoreg(i_stg_memtoreg), .o_sel(o_fw_b));

    hazard_fwd_match #(.NUM_FWD_STAGES(NUM_FWD_STAGES), .LOAD_LATENCY(LOAD_LATENCY), .SEL_W(SEL_W)) u_match_sd (
        .i_reg(i_ex_rs2), .i_en(i_ex_mem_write), .i_stg_wreg(i_stg_wreg),
        .i_stg_regwrite(i_stg_regwrite), .i_stg_memtoreg(i_stg_memtoreg), .o_sel(o_fw_sd));

    assign w_hazard = i_id_ex_memtoreg && i_id_ex_wreg != 5'd0 &&
                      ((i_id_use_rs1 && i_id_rs1 == i_id_ex_wreg) || (i_id_use_rs2 && i_id_rs2 == i_id_ex_wreg));

    // Leaving MEM_WAIT behaves as the saved state in the same cycle, so no dead cycle is added.
    assign w_eff   = (r_state == ST_MEM_WAIT) ? r_ret : r_state;
    assign w_stall = !i_dmem_busy && !i_flush && ((w_eff == ST_RUN && w_hazard) || w_eff == ST_LU_STALL);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
            r_ret   <= ST_RUN;
            r_cnt   <= '0;
        end else if (i_dmem_busy) begin
            r_state <= ST_MEM_WAIT;
            if (r_state != ST_MEM_WAIT)
                r_ret <= r_state;
        end else if (i_flush) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (w_eff == ST_RUN && w_hazard) begin
            r_cnt   <= CW'(LOAD_LATENCY-1);
            r_state <= (LOAD_LATENCY > 1) ? ST_LU_STALL : ST_RUN;
        end else if (w_eff == ST_LU_STALL) begin
            r_cnt   <= r_cnt - 1'b1;
            r_state <= (r_cnt == CW'(1)) ? ST_RUN : ST_LU_STALL;
        end else begin
            r_state <= w_eff;
        end
    end

    // Gating with reset makes the controls drop the moment reset rises, not at the next edge.
    assign o_idex_bubble = !i_reset && w_stall;
    assign o_freeze      = !i_reset && i_dmem_busy;
    assign o_pc_hold     = !i_reset && (w_stall || i_dmem_busy);
    assign o_ifid_hold   = o_pc_hold;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles, r_fwd_events;
    logic        w_any_fwd;

    assign w_any_fwd = |{o_fw_a, o_fw_b, o_fw_sd};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
            r_fwd_events   <= '0;
        end else begin
            if (o_pc_hold)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_any_fwd)
                r_fwd_events <= r_fwd_events + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_fwd_events   = r_fwd_events;
`else
    assign o_stall_cycles = '0;
    assign o_fwd_events   = '0;
`endif

endmodule

// File: tb/tb_riscv_hazard_fwd_unit.sv
// tb_riscv_hazard_fwd_unit: checks two configurations (2 stages/latency 1 and 3 stages/latency 2) against a reference model.
module tb_riscv_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, id_ex_wreg;
    logic        use_rs1, use_rs2, b_imm, mem_write, id_ex_ld, flush, busy;
    logic [14:0] stg_wreg;
    logic [2:0]  stg_rw, stg_ld;

    logic [1:0]  fa[2], fb[2], fs[2];
    logic        ph[2], ih[2], bub[2], frz[2];
    logic [31:0] sco[2], feo[2];

    int          exp_left[2];
    logic [31:0] exp_sc[2], exp_fe[2];
    int          vectors = 0, miscompares = 0;
    int          nb, nf;

    always #5 clk = !clk;

    riscv_hazard_fwd_unit #(.NUM_FWD_STAGES(2), .LOAD_LATENCY(1)) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(use_rs1), .i_id_use_rs2(use_rs2), .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
        .i_ex_b_is_imm(b_imm), .i_ex_mem_write(mem_write), .i_id_ex_wreg(id_ex_wreg),
        .i_id_ex_memtoreg(id_ex_ld), .i_stg_wreg(stg_wreg[9:0]), .i_stg_regwrite(stg_rw[1:0]),
        .i_stg_memtoreg(stg_ld[1:0]), .i_flush(flush), .i_dmem_busy(busy),
        .o_fw_a(fa[0]), .o_fw_b(fb[0]), .o_fw_sd(fs[0]), .o_pc_hold(ph[0]), .o_ifid_hold(ih[0]),
        .o_idex_bubble(bub[0]), .o_freeze(frz[0]), .o_stall_cycles(sco[0]), .o_fwd_events(feo[0]));

    riscv_hazard_fwd_unit #(.NUM_FWD_STAGES(3), .LOAD_LATENCY(2)) u_dut3 (
        .i_clk(clk), .i_reset(rst), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(use_rs1), .i_id_use_rs2(use_rs2), .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2),
        .i_ex_b_is_imm(b_imm), .i_ex_mem_write(mem_write), .i_id_ex_wreg(id_ex_wreg),
        .i_id_ex_memtoreg(id_ex_ld), .i_stg_wreg(stg_wreg), .i_stg_regwrite(stg_rw),
        .i_stg_memtoreg(stg_ld), .i_flush(flush), .i_dmem_busy(busy),
        .o_fw_a(fa[1]), .o_fw_b(fb[1]), .o_fw_sd(fs[1]), .o_pc_hold(ph[1]), .o_ifid_hold(ih[1]),
        .o_idex_bubble(bub[1]), .o_freeze(frz[1]), .o_stall_cycles(sco[1]), .o_fwd_events(feo[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fwd_ref(int n, int ll, logic [4:0] r, logic en);
        logic [4:0] w;
        for (int k = 1; k <= n; k++) begin
            w = stg_wreg[5*k-5 +: 5];
            if (en && stg_rw[k-1] && w != 0 && w == r && !(stg_ld[k-1] && k <= ll))
                return k;
        end
        return 0;
    endfunction

    function automatic bit hazard_ref();
        return id_ex_ld && id_ex_wreg != 0 &&
               ((use_rs1 && id_rs1 == id_ex_wreg) || (use_rs2 && id_rs2 == id_ex_wreg));
    endfunction

    // Model: a count of stall cycles still owed; busy pauses it, flush cancels it.
    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int n, ll, ea, eb, es;
            bit hz, st, hold, fr;
            n  = (d == 1) ? 3 : 2;
            ll = (d == 1) ? 2 : 1;
            ea = fwd_ref(n, ll, ex_rs1, 1'b1);
            eb = fwd_ref(n, ll, ex_rs2, !b_imm);
            es = fwd_ref(n, ll, ex_rs2, mem_write);
            hz = hazard_ref();
            if (rst) begin
                exp_left[d] = 0;
                exp_sc[d]   = 0;
                exp_fe[d]   = 0;
            end
            st   = !rst && !busy && !flush && (exp_left[d] > 0 || hz);
            hold = !rst && (st || busy);
            fr   = !rst && busy;
            chk($sformatf("fw_a[%0d]", d), 32'(fa[d]), 32'(ea));
            chk($sformatf("fw_b[%0d]", d), 32'(fb[d]), 32'(eb));
            chk($sformatf("fw_sd[%0d]", d), 32'(fs[d]), 32'(es));
            chk($sformatf("pc_hold[%0d]", d), 32'(ph[d]), 32'(hold));
            chk($sformatf("ifid_hold[%0d]", d), 32'(ih[d]), 32'(hold));
            chk($sformatf("idex_bubble[%0d]", d), 32'(bub[d]), 32'(st));
            chk($sformatf("freeze[%0d]", d), 32'(frz[d]), 32'(fr));
`ifdef HAZARD_STATS_EN
            chk($sformatf("stall_cycles[%0d]", d), sco[d], exp_sc[d]);
            chk($sformatf("fwd_events[%0d]", d), feo[d], exp_fe[d]);
`else
            chk($sformatf("stall_cycles[%0d]", d), sco[d], 32'd0);
            chk($sformatf("fwd_events[%0d]", d), feo[d], 32'd0);
`endif
            if (!rst) begin
                exp_sc[d] += 32'(hold);
                exp_fe[d] += 32'((ea | eb | es) != 0);
                if (busy)
                    ;
                else if (flush)
                    exp_left[d] = 0;
                else if (exp_left[d] > 0)
                    exp_left[d]--;
                else if (hz)
                    exp_left[d] = ll - 1;
            end
        end
    endtask

    always @(negedge clk) begin
        #1 check_all();
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #2;
    endtask

    task automatic clr();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, id_ex_wreg} = '0;
        {use_rs1, use_rs2, b_imm, mem_write, id_ex_ld, flush, busy} = '0;
        stg_wreg = '0;
        stg_rw   = '0;
        stg_ld   = '0;
    endtask

    task automatic set_stg(input int k, input logic [4:0] r, input logic rw, input logic ld);
        stg_wreg[5*k-5 +: 5] = r;
        stg_rw[k-1] = rw;
        stg_ld[k-1] = ld;
    endtask

    task automatic load_use();
        clr();
        id_ex_ld   = 1'b1;
        id_ex_wreg = 5'd7;
        id_rs2     = 5'd7;
        use_rs2    = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        drive();
        drive();
        rst = 1'b0;

        drive(); clr(); ex_rs1 = 5'd5; set_stg(1, 5'd5, 1'b1, 1'b0); set_stg(2, 5'd5, 1'b1, 1'b0);
        look(); chk("nearest", 32'(fa[0]), 32'd1);
        drive(); set_stg(1, 5'd0, 1'b0, 1'b0);
        look(); chk("far", 32'(fa[0]), 32'd2);
        drive(); clr(); set_stg(1, 5'd0, 1'b1, 1'b0);
        look(); chk("x0", 32'(fa[0]), 32'd0);
        drive(); clr(); set_stg(1, 5'd5, 1'b1, 1'b0); ex_rs2 = 5'd5; b_imm = 1'b1;
        look(); chk("imm", 32'(fb[0]), 32'd0); chk("sd_off", 32'(fs[0]), 32'd0);
        drive(); mem_write = 1'b1;
        look(); chk("sd_on", 32'(fs[0]), 32'd1);

        drive(); load_use();
        look(); chk("lu_c1", 32'(bub[1]), 32'd1);
        drive(); clr(); set_stg(1, 5'd7, 1'b1, 1'b1); ex_rs2 = 5'd7;
        look(); chk("lu_c2", 32'(bub[1]), 32'd1); chk("ld_s1", 32'(fb[1]), 32'd0);
        drive(); clr(); set_stg(2, 5'd7, 1'b1, 1'b1); ex_rs2 = 5'd7;
        look(); chk("lu_c3", 32'(bub[1]), 32'd0); chk("ld_s2", 32'(fb[1]), 32'd0);
        drive(); clr(); set_stg(3, 5'd7, 1'b1, 1'b1); ex_rs2 = 5'd7;
        look(); chk("ld_s3", 32'(fb[1]), 32'd3);

        drive(); clr(); rst = 1'b1;
        drive(); rst = 1'b0;
        nb = 0;
        nf = 0;
        drive(); load_use();
        look(); nb += int'(bub[1]); nf += int'(frz[1]);
        for (int i = 0; i < 3; i++) begin
            drive(); clr(); busy = 1'b1;
            look(); nb += int'(bub[1]); nf += int'(frz[1]);
            chk("frz_nobub", 32'(bub[1]), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(); clr();
            look(); nb += int'(bub[1]); nf += int'(frz[1]);
        end
        chk("stall_total", 32'(nb), 32'd2);
        chk("freeze_total", 32'(nf), 32'd3);
`ifdef HAZARD_STATS_EN
        chk("stats5", sco[1], 32'd5);
`else
        chk("stats0", sco[1], 32'd0);
`endif

        drive(); load_use(); flush = 1'b1;
        look(); chk("flush_bub", 32'(bub[1]), 32'd0); chk("flush_hold", 32'(ph[1]), 32'd0);
        drive(); clr();
        look(); chk("flush_after", 32'(bub[1]), 32'd0);

        drive(); load_use();
        look();
        drive(); clr();
        look(); chk("lu_mid", 32'(bub[1]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_bub", 32'(bub[1]), 32'd0);
        chk("rst_hold", 32'(ph[1]), 32'd0);
        chk("rst_ifid", 32'(ih[1]), 32'd0);
        chk("rst_frz", 32'(frz[1]), 32'd0);
        drive(); rst = 1'b0;
        look(); chk("post_rst1", 32'(bub[1]), 32'd0);
        drive();
        look(); chk("post_rst2", 32'(bub[1]), 32'd0);

        repeat (400) begin
            drive();
            ex_rs1     = 5'($urandom_range(0, 3));
            ex_rs2     = 5'($urandom_range(0, 3));
            id_rs1     = 5'($urandom_range(0, 3));
            id_rs2     = 5'($urandom_range(0, 3));
            id_ex_wreg = 5'($urandom_range(0, 3));
            stg_wreg   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            stg_rw     = 3'($urandom);
            stg_ld     = 3'($urandom);
            {use_rs1, use_rs2, b_imm, mem_write, id_ex_ld} = 5'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            busy       = ($urandom_range(0, 7) == 0);
            rst        = ($urandom_range(0, 63) == 0);
        end
        drive(); clr(); rst = 1'b0;
        look();
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
